regfile_scrub_arbiter: RTL and testbench

REGFILE_SCRUB_ARBITER -- requirements
Module: regfile_scrub_arbiter

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/rr_arbiter2.sv | 43 ++++
 rtl/regfile_scrub_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_regfile_scrub_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file scrub arbiter: FSM state codes,
// ECC status codes reported by the register file, and requester indices.
package regfile_pkg;

    // FSM state encoding (kept as plain constants for legacy tool flows)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'b00;
    localparam state_t ST_ACCESS   = 2'b01;
    localparam state_t ST_SCRUB_RD = 2'b10;
    localparam state_t ST_SCRUB_WR = 2'b11;

    // ECC result returned alongside rf_ready_i; 2'b11 is handled like UNCORR
    typedef logic [1:0] ecc_status_t;
    localparam ecc_status_t ECC_CLEAN  = 2'b00;
    localparam ecc_status_t ECC_CORR   = 2'b01;
    localparam ecc_status_t ECC_UNCORR = 2'b10;

    // Requester indices into req_i / we_i / ack_o and the packed address/data buses
    localparam int REQ_WB = 0;
    localparam int REQ_LA = 1;

    // Any status other than CLEAN is an ECC event worth counting
    function automatic logic ecc_is_event(input ecc_status_t status);
        return status != ECC_CLEAN;
    endfunction

    // Bit 1 set covers both UNCORR and the reserved 2'b11 code
    function automatic logic ecc_is_uncorr(input ecc_status_t status);
        return status[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. On a tie the requester that was not
// granted most recently wins; after reset requester 0 is favoured.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    logic prefer_q;
    logic prefer_d;
    logic idx;

    // Pick the winner for this cycle and the favoured requester for the next tie
    always_comb begin
        idx = 1'b0;
        if (req_i == 2'b11) begin
            idx = prefer_q;
        end else if (req_i[REQ_LA]) begin
            idx = 1'b1;
        end
        gnt_o     = (req_i != 2'b00) ? (idx ? 2'b10 : 2'b01) : 2'b00;
        gnt_idx_o = idx;
        prefer_d  = prefer_q;
        if (accept_i && (req_i != 2'b00)) begin
            prefer_d = ~idx;
        end
    end

    // Remember which requester gets priority on the next tie
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prefer_q <= 1'b0;
        end else begin
            prefer_q <= prefer_d;
        end
    end

endmodule

// File: rtl/regfile_scrub_arbiter.sv
// Arbitrates wishbone and logic-analyzer accesses onto a single ECC-protected
// register-file port, and fills idle time with background scrub reads that
// write back corrected words. Tracks ECC events and a sticky uncorrectable flag.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | no transaction; arbitrate requests or count toward a scrub
// ST_ACCESS    | requester transaction outstanding, waiting for rf_ready_i
// ST_SCRUB_RD  | scrub read of scrub_ptr outstanding
// ST_SCRUB_WR  | write-back of the corrected scrub word outstanding
module regfile_scrub_arbiter
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int REGISTERS      = 32,
    parameter int REGDIRSIZE     = 5,
    parameter int COUNTERSIZE    = 32,
    parameter int SCRUB_INTERVAL = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_i,
    input  logic [1:0]              we_i,
    input  logic [2*REGDIRSIZE-1:0] addr_i,
    input  logic [2*WORD_SIZE-1:0]  wdata_i,
    output logic [1:0]              ack_o,
    output logic [WORD_SIZE-1:0]    rdata_o,
    output logic                    rf_valid_o,
    output logic                    rf_we_o,
    output logic [REGDIRSIZE-1:0]   rf_addr_o,
    output logic [WORD_SIZE-1:0]    rf_wdata_o,
    input  logic [WORD_SIZE-1:0]    rf_rdata_i,
    input  logic                    rf_ready_i,
    input  logic [1:0]              rf_status_i,
    input  logic                    scrub_en_i,
    output logic [COUNTERSIZE-1:0]  err_count_o,
    output logic                    uncorr_o
);

    localparam int IDLE_W = $clog2(SCRUB_INTERVAL + 1);
    localparam logic [IDLE_W-1:0]     IDLE_LAST = IDLE_W'(SCRUB_INTERVAL - 1);
    localparam logic [REGDIRSIZE-1:0] PTR_LAST  = REGDIRSIZE'(REGISTERS - 1);

    state_t                  state_q,     state_d;
    logic                    rf_valid_q,  rf_valid_d;
    logic                    rf_we_q,     rf_we_d;
    logic [REGDIRSIZE-1:0]   rf_addr_q,   rf_addr_d;
    logic [WORD_SIZE-1:0]    rf_wdata_q,  rf_wdata_d;
    logic [1:0]              ack_q,       ack_d;
    logic [WORD_SIZE-1:0]    rdata_q,     rdata_d;
    logic                    gnt_idx_q,   gnt_idx_d;
    logic [IDLE_W-1:0]       idle_cnt_q,  idle_cnt_d;
    logic [REGDIRSIZE-1:0]   scrub_ptr_q, scrub_ptr_d;
    logic [COUNTERSIZE-1:0]  err_cnt_q,   err_cnt_d;
    logic                    uncorr_q,    uncorr_d;

    logic       grant_accept;
    logic [1:0] arb_gnt;
    logic       arb_idx;
    logic       rf_done;

    rr_arbiter2 u_rr_arbiter2 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .accept_i  (grant_accept),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    // Completion only counts for a transaction we actually have outstanding
    assign rf_done = rf_valid_q && rf_ready_i;

    // Next-state, transaction fields, scrub bookkeeping and ECC event tracking
    always_comb begin
        state_d      = state_q;
        rf_valid_d   = rf_valid_q;
        rf_we_d      = rf_we_q;
        rf_addr_d    = rf_addr_q;
        rf_wdata_d   = rf_wdata_q;
        ack_d        = 2'b00;
        rdata_d      = rdata_q;
        gnt_idx_d    = gnt_idx_q;
        idle_cnt_d   = idle_cnt_q;
        scrub_ptr_d  = scrub_ptr_q;
        err_cnt_d    = err_cnt_q;
        uncorr_d     = uncorr_q;
        grant_accept = 1'b0;

        if (rf_done && ecc_is_event(rf_status_i)) begin
            if (err_cnt_q != {COUNTERSIZE{1'b1}}) begin
                err_cnt_d = err_cnt_q + COUNTERSIZE'(1);
            end
            if (ecc_is_uncorr(rf_status_i)) begin
                uncorr_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    grant_accept = 1'b1;
                    gnt_idx_d    = arb_idx;
                    rf_valid_d   = 1'b1;
                    rf_we_d      = arb_idx ? we_i[REQ_LA] : we_i[REQ_WB];
                    rf_addr_d    = arb_idx ? addr_i[2*REGDIRSIZE-1:REGDIRSIZE]
                                           : addr_i[REGDIRSIZE-1:0];
                    rf_wdata_d   = arb_idx ? wdata_i[2*WORD_SIZE-1:WORD_SIZE]
                                           : wdata_i[WORD_SIZE-1:0];
                    idle_cnt_d   = '0;
                    state_d      = ST_ACCESS;
                end else if (!scrub_en_i) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    idle_cnt_d = '0;
                    rf_valid_d = 1'b1;
                    rf_we_d    = 1'b0;
                    rf_addr_d  = scrub_ptr_q;
                    state_d    = ST_SCRUB_RD;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end

            ST_ACCESS: begin
                if (rf_ready_i) begin
                    rf_valid_d = 1'b0;
                    rf_we_d    = 1'b0;
                    rdata_d    = rf_rdata_i;
                    ack_d      = gnt_idx_q ? 2'b10 : 2'b01;
                    state_d    = ST_IDLE;
                end
            end

            ST_SCRUB_RD: begin
                if (rf_ready_i) begin
                    if (rf_status_i == ECC_CORR) begin
                        // Keep the port busy and turn straight into the write-back
                        rf_we_d    = 1'b1;
                        rf_wdata_d = rf_rdata_i;
                        state_d    = ST_SCRUB_WR;
                    end else begin
                        rf_valid_d  = 1'b0;
                        scrub_ptr_d = (scrub_ptr_q == PTR_LAST) ? '0
                                      : scrub_ptr_q + REGDIRSIZE'(1);
                        state_d     = ST_IDLE;
                    end
                end
            end

            ST_SCRUB_WR: begin
                if (rf_ready_i) begin
                    rf_valid_d  = 1'b0;
                    rf_we_d     = 1'b0;
                    scrub_ptr_d = (scrub_ptr_q == PTR_LAST) ? '0
                                  : scrub_ptr_q + REGDIRSIZE'(1);
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                rf_valid_d = 1'b0;
                rf_we_d    = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any outstanding transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rf_valid_q  <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
            ack_q       <= 2'b00;
            rdata_q     <= '0;
            gnt_idx_q   <= 1'b0;
            idle_cnt_q  <= '0;
            scrub_ptr_q <= '0;
            err_cnt_q   <= '0;
            uncorr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_valid_q  <= rf_valid_d;
            rf_we_q     <= rf_we_d;
            rf_addr_q   <= rf_addr_d;
            rf_wdata_q  <= rf_wdata_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            gnt_idx_q   <= gnt_idx_d;
            idle_cnt_q  <= idle_cnt_d;
            scrub_ptr_q <= scrub_ptr_d;
            err_cnt_q   <= err_cnt_d;
            uncorr_q    <= uncorr_d;
        end
    end

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign rf_valid_o  = rf_valid_q;
    assign rf_we_o     = rf_we_q;
    assign rf_addr_o   = rf_addr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign err_count_o = err_cnt_q;
    assign uncorr_o    = uncorr_q;

endmodule

// File: tb/tb_regfile_scrub_arbiter.sv
// Directed bench for regfile_scrub_arbiter: the bench plays the register file
// by driving rf_ready_i/rf_status_i/rf_rdata_i by hand. Inputs change and
// outputs are sampled on the falling edge.
module tb_regfile_scrub_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [9:0]  addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  ack_o;
    logic [31:0] rdata_o;
    logic        rf_valid_o;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] rf_rdata_i;
    logic        rf_ready_i;
    logic [1:0]  rf_status_i;
    logic        scrub_en_i;
    logic [31:0] err_count_o;
    logic        uncorr_o;

    int n_checks = 0;
    int n_errors = 0;

    regfile_scrub_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .rf_valid_o  (rf_valid_o),
        .rf_we_o     (rf_we_o),
        .rf_addr_o   (rf_addr_o),
        .rf_wdata_o  (rf_wdata_o),
        .rf_rdata_i  (rf_rdata_i),
        .rf_ready_i  (rf_ready_i),
        .rf_status_i (rf_status_i),
        .scrub_en_i  (scrub_en_i),
        .err_count_o (err_count_o),
        .uncorr_o    (uncorr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Finish the outstanding transaction after 'delay' extra cycles; returns
    // on the falling edge where the ack (if any) is visible.
    task automatic rf_complete(input int delay, input logic [1:0] st, input logic [31:0] d);
        repeat (delay) @(negedge clk_i);
        rf_ready_i  = 1'b1;
        rf_status_i = st;
        rf_rdata_i  = d;
        @(negedge clk_i);
        rf_ready_i  = 1'b0;
        rf_status_i = 2'b00;
        rf_rdata_i  = '0;
    endtask

    // Called on the first idle falling edge: the scrub read must appear on the 16th edge
    task automatic wait_scrub(input logic [4:0] exp_addr);
        repeat (15) @(negedge clk_i);
        chk("scrub_not_early", {63'd0, rf_valid_o}, 64'd0);
        @(negedge clk_i);
        chk("scrub_valid", {63'd0, rf_valid_o}, 64'd1);
        chk("scrub_rd_we", {63'd0, rf_we_o}, 64'd0);
        chk("scrub_addr", {59'd0, rf_addr_o}, {59'd0, exp_addr});
    endtask

    task automatic reset_pulse();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        req_i       = 2'b00;
        we_i        = 2'b00;
        addr_i      = '0;
        wdata_i     = '0;
        rf_rdata_i  = '0;
        rf_ready_i  = 1'b0;
        rf_status_i = 2'b00;
        scrub_en_i  = 1'b0;

        // Reset values
        @(negedge clk_i);
        chk("rst_valid", {63'd0, rf_valid_o}, 64'd0);
        chk("rst_ack", {62'd0, ack_o}, 64'd0);
        chk("rst_err", {32'd0, err_count_o}, 64'd0);
        chk("rst_uncorr", {63'd0, uncorr_o}, 64'd0);
        chk("rst_rdata", {32'd0, rdata_o}, 64'd0);
        rst_i = 1'b0;

        // Single wishbone write to 5, ready two cycles after issue
        req_i   = 2'b01;
        we_i    = 2'b01;
        addr_i  = {5'd0, 5'd5};
        wdata_i = {32'd0, 32'hDEADBEEF};
        @(negedge clk_i);
        req_i = 2'b00;
        chk("wb_wr_valid", {63'd0, rf_valid_o}, 64'd1);
        chk("wb_wr_we", {63'd0, rf_we_o}, 64'd1);
        chk("wb_wr_addr", {59'd0, rf_addr_o}, 64'd5);
        chk("wb_wr_wdata", {32'd0, rf_wdata_o}, 64'hDEADBEEF);
        @(negedge clk_i);
        chk("wb_wr_hold_valid", {63'd0, rf_valid_o}, 64'd1);
        chk("wb_wr_hold_addr", {59'd0, rf_addr_o}, 64'd5);
        rf_complete(1, 2'b00, 32'h0);
        chk("wb_wr_ack", {62'd0, ack_o}, 64'd1);
        chk("wb_wr_done_valid", {63'd0, rf_valid_o}, 64'd0);
        @(negedge clk_i);
        chk("wb_wr_ack_pulse", {62'd0, ack_o}, 64'd0);

        // Both requesters held: grants alternate 0,1,0,1 starting fresh from reset
        reset_pulse();
        req_i  = 2'b11;
        we_i   = 2'b00;
        addr_i = {5'd2, 5'd1};
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            chk("rr_addr", {59'd0, rf_addr_o}, (i % 2 == 0) ? 64'd1 : 64'd2);
            rf_complete(0, 2'b00, 32'hA0 + i);
            chk("rr_ack", {62'd0, ack_o}, (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr_rdata", {32'd0, rdata_o}, 64'hA0 + i);
            if (i < 3) begin
                @(negedge clk_i);
                chk("rr_ack_pulse", {62'd0, ack_o}, 64'd0);
            end else begin
                req_i = 2'b00;
            end
        end
        @(negedge clk_i);
        chk("rr_idle", {63'd0, rf_valid_o}, 64'd0);

        // LA read with uncorrectable status
        req_i  = 2'b10;
        we_i   = 2'b00;
        addr_i = {5'd7, 5'd0};
        @(negedge clk_i);
        req_i = 2'b00;
        chk("la_addr", {59'd0, rf_addr_o}, 64'd7);
        chk("la_we", {63'd0, rf_we_o}, 64'd0);
        rf_complete(1, 2'b10, 32'hCAFEF00D);
        chk("la_ack", {62'd0, ack_o}, 64'd2);
        chk("la_rdata", {32'd0, rdata_o}, 64'hCAFEF00D);
        chk("la_uncorr", {63'd0, uncorr_o}, 64'd1);
        chk("la_err", {32'd0, err_count_o}, 64'd1);
        @(negedge clk_i);
        chk("la_no_wb", {63'd0, rf_valid_o}, 64'd0);
        chk("la_uncorr_sticky", {63'd0, uncorr_o}, 64'd1);

        // Status 11 behaves like uncorrectable
        req_i  = 2'b01;
        addr_i = {5'd0, 5'd4};
        @(negedge clk_i);
        req_i = 2'b00;
        rf_complete(0, 2'b11, 32'h55);
        chk("st11_ack", {62'd0, ack_o}, 64'd1);
        chk("st11_err", {32'd0, err_count_o}, 64'd2);
        chk("st11_uncorr", {63'd0, uncorr_o}, 64'd1);

        // Reset clears counters and the sticky flag
        rst_i = 1'b1;
        #1;
        chk("rst2_err", {32'd0, err_count_o}, 64'd0);
        chk("rst2_uncorr", {63'd0, uncorr_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Background scrub: first read of 0 corrected and written back
        scrub_en_i = 1'b1;
        wait_scrub(5'd0);
        rf_complete(0, 2'b01, 32'h12345678);
        chk("scrub_wb_valid", {63'd0, rf_valid_o}, 64'd1);
        chk("scrub_wb_we", {63'd0, rf_we_o}, 64'd1);
        chk("scrub_wb_addr", {59'd0, rf_addr_o}, 64'd0);
        chk("scrub_wb_data", {32'd0, rf_wdata_o}, 64'h12345678);
        chk("scrub_wb_err", {32'd0, err_count_o}, 64'd1);
        chk("scrub_wb_uncorr", {63'd0, uncorr_o}, 64'd0);
        chk("scrub_no_ack", {62'd0, ack_o}, 64'd0);
        rf_complete(0, 2'b00, 32'h0);
        chk("scrub_wb_done", {63'd0, rf_valid_o}, 64'd0);

        // Walk the pointer through the rest of the file and check the wrap
        for (int i = 1; i < 32; i++) begin
            wait_scrub(5'(i));
            rf_complete(0, 2'b00, 32'h0);
        end
        wait_scrub(5'd0);
        rf_complete(0, 2'b10, 32'h0);
        chk("scrub_uncorr_no_wb", {63'd0, rf_valid_o}, 64'd0);
        chk("scrub_uncorr_flag", {63'd0, uncorr_o}, 64'd1);
        chk("scrub_uncorr_err", {32'd0, err_count_o}, 64'd2);

        // A request arriving mid-scrub waits for the scrub to finish
        wait_scrub(5'd1);
        req_i   = 2'b01;
        we_i    = 2'b01;
        addr_i  = {5'd0, 5'd3};
        wdata_i = {32'd0, 32'h77};
        @(negedge clk_i);
        chk("wait_scrub_addr", {59'd0, rf_addr_o}, 64'd1);
        chk("wait_scrub_we", {63'd0, rf_we_o}, 64'd0);
        rf_complete(0, 2'b00, 32'h0);
        chk("wait_gap", {63'd0, rf_valid_o}, 64'd0);
        @(negedge clk_i);
        req_i      = 2'b00;
        scrub_en_i = 1'b0;
        chk("wait_grant_addr", {59'd0, rf_addr_o}, 64'd3);
        chk("wait_grant_we", {63'd0, rf_we_o}, 64'd1);
        rf_complete(0, 2'b00, 32'h0);
        chk("wait_ack", {62'd0, ack_o}, 64'd1);
        @(negedge clk_i);

        // Reset in the middle of an access: strobe drops at once, no ack ever
        req_i  = 2'b01;
        we_i   = 2'b01;
        addr_i = {5'd0, 5'd9};
        @(negedge clk_i);
        req_i = 2'b00;
        chk("abort_valid_before", {63'd0, rf_valid_o}, 64'd1);
        rst_i = 1'b1;
        #1;
        chk("abort_valid", {63'd0, rf_valid_o}, 64'd0);
        chk("abort_ack", {62'd0, ack_o}, 64'd0);
        chk("abort_err", {32'd0, err_count_o}, 64'd0);
        chk("abort_addr", {59'd0, rf_addr_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rf_complete(0, 2'b10, 32'h0);
        chk("abort_no_ack", {62'd0, ack_o}, 64'd0);
        chk("abort_err_after", {32'd0, err_count_o}, 64'd0);
        chk("abort_uncorr_after", {63'd0, uncorr_o}, 64'd0);
        @(negedge clk_i);
        chk("abort_no_ack_late", {62'd0, ack_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
